button_event_decoder: RTL and testbench



---
 rtl/button_pkg.sv | 26 ++
 rtl/button_event_decoder_if.sv | 24 ++
 rtl/button_debouncer.sv | 39 +++
 rtl/button_event_decoder.sv | 121 ++++++++++++
 tb/tb_button_event_decoder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types, default timing constants and helpers for the button event decoder.
package button_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ = 25_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_MS = 10;
    localparam int unsigned DEFAULT_LONG_MS = 1000;
    localparam int unsigned DEFAULT_GAP_MS = 300;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        HELD   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } btn_evt_state_t;

    // Divide first so large clock rates cannot overflow 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq, input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic int unsigned cfg_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button pin plus decoded level and one-cycle gesture events.
interface button_event_decoder_if;
    logic btn;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_press;

    modport master (
        input  btn,
        output btn_level,
        output short_press,
        output long_press,
        output double_press
    );

    modport slave (
        output btn,
        input  btn_level,
        input  short_press,
        input  long_press,
        input  double_press
    );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser and stability counter producing a debounced button level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_level
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             btn_m;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    // Count restarts on any agreement, so bounces shorter than the window are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m     <= 1'b0;
            btn_s     <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            if (btn_s == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_DONE) begin
                btn_level <= ~btn_level;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Debounces the push-button and classifies presses into short, long and double events.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = DEFAULT_CLK_FREQ,
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_FREQ, DEFAULT_DEBOUNCE_MS),
    parameter int unsigned LONG_CYCLES     = ms_to_cycles(CLK_FREQ, DEFAULT_LONG_MS),
    parameter int unsigned GAP_CYCLES      = ms_to_cycles(CLK_FREQ, DEFAULT_GAP_MS)
) (
    input  logic                  clk,
    input  logic                  rst,
    button_event_decoder_if.master bus
);

    localparam int unsigned TMR_W = $clog2(cfg_max(LONG_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = '1;

    localparam logic [2:0] ST_IDLE   = 3'(IDLE);
    localparam logic [2:0] ST_PRESS1 = 3'(PRESS1);
    localparam logic [2:0] ST_HELD   = 3'(HELD);
    localparam logic [2:0] ST_GAP    = 3'(GAP);
    localparam logic [2:0] ST_PRESS2 = 3'(PRESS2);

    logic             level;
    logic             level_q;
    logic             rise_c;
    logic             fall_c;
    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [TMR_W-1:0] timer;
    logic             short_next;
    logic             long_next;
    logic             double_next;
    logic             short_q;
    logic             long_q;
    logic             double_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .btn      (bus.btn),
        .btn_level(level)
    );

    assign rise_c = level & ~level_q;
    assign fall_c = ~level & level_q;

    // Gesture classifier; in GAP a new press beats the timeout on the same cycle.
    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_c) state_next = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall_c) begin
                    state_next = ST_GAP;
                end else if (timer == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall_c) state_next = ST_IDLE;
            end
            ST_GAP: begin
                if (rise_c) begin
                    state_next = ST_PRESS2;
                end else if (timer == GAP_LAST) begin
                    short_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (fall_c) begin
                    double_next = 1'b1;
                    state_next  = ST_IDLE;
                end else if (timer == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = ST_HELD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            level_q  <= 1'b0;
            timer    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state    <= state_next;
            level_q  <= level;
            short_q  <= short_next;
            long_q   <= long_next;
            double_q <= double_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    assign bus.btn_level    = level;
    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_press = double_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timing parameters.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .CLK_FREQ       (1000),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .GAP_CYCLES     (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    int rise_first, rise_last, fall_first, fall_last;
    int n_short, n_long, n_double;
    int short_first, short_last, long_e, double_e;
    int multi;
    int out_at_rst;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // btn pattern: high a, low b, high c, then low; optional reset window in edge units.
    task automatic run(input int a, input int b, input int c, input int n,
                       input int rst_at, input int rst_len);
        logic prev;
        int   hot;
        rise_first = -1; rise_last = -1; fall_first = -1; fall_last = -1;
        n_short = 0; n_long = 0; n_double = 0;
        short_first = -1; short_last = -1; long_e = -1; double_e = -1;
        multi = 0; out_at_rst = -1;
        prev = bus.btn_level;
        for (int i = 0; i < n; i++) begin
            bus.btn = (i < a) ? 1'b1 : (i < a + b) ? 1'b0 : (i < a + b + c) ? 1'b1 : 1'b0;
            rst     = (i >= rst_at) && (i < rst_at + rst_len);
            @(posedge clk);
            #1;
            if (bus.btn_level && !prev) begin
                if (rise_first < 0) rise_first = i;
                rise_last = i;
            end
            if (!bus.btn_level && prev) begin
                if (fall_first < 0) fall_first = i;
                fall_last = i;
            end
            prev = bus.btn_level;
            if (bus.short_press) begin
                n_short++;
                if (short_first < 0) short_first = i;
                short_last = i;
            end
            if (bus.long_press) begin
                n_long++;
                long_e = i;
            end
            if (bus.double_press) begin
                n_double++;
                double_e = i;
            end
            hot = int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press);
            if (hot > 1) multi++;
            if (i == rst_at)
                out_at_rst = int'({bus.btn_level, bus.short_press, bus.long_press, bus.double_press});
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_btn_level", int'(bus.btn_level), 0);
        check("reset_short", int'(bus.short_press), 0);
        check("reset_long", int'(bus.long_press), 0);
        check("reset_double", int'(bus.double_press), 0);
        rst = 1'b0;

        // Bounce rejection
        do_reset();
        run(2, 3, 1, 40, -10, 0);
        check("bounce_rise", rise_first, -1);
        check("bounce_events", n_short + n_long + n_double, 0);

        // Short press
        do_reset();
        run(10, 0, 0, 45, -10, 0);
        check("short_rise", rise_first, 6);
        check("short_fall", fall_first, 16);
        check("short_count", n_short, 1);
        check("short_edge", short_first, 27);
        check("short_other", n_long + n_double, 0);

        // Long press, no event on release
        do_reset();
        run(40, 0, 0, 70, -10, 0);
        check("long_rise", rise_first, 6);
        check("long_count", n_long, 1);
        check("long_edge", long_e, 27);
        check("long_release_fall", fall_first, 46);
        check("long_other", n_short + n_double, 0);

        // Double press
        do_reset();
        run(8, 6, 8, 60, -10, 0);
        check("double_fall2", fall_last, 28);
        check("double_count", n_double, 1);
        check("double_edge", double_e, 29);
        check("double_other", n_short + n_long, 0);
        check("double_multi", multi, 0);

        // Gap timeout: two short presses
        do_reset();
        run(8, 20, 8, 70, -10, 0);
        check("gap_short_count", n_short, 2);
        check("gap_short_first", short_first, 25);
        check("gap_short_last", short_last, 53);
        check("gap_double", n_double, 0);
        check("gap_long", n_long, 0);

        // Reset mid-gesture while held in PRESS1
        do_reset();
        run(60, 0, 0, 50, 10, 2);
        check("rst_first_rise", rise_first, 6);
        check("rst_outputs", out_at_rst, 0);
        check("rst_rerise", rise_last, 18);
        check("rst_long_count", n_long, 1);
        check("rst_long_edge", long_e, 39);
        check("rst_other", n_short + n_double, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
